// File: rtl/tap_vector_encoder_if.sv
// Tap-vector encoder bus: tracking enable and raw tap vector in, locked code and status out.
interface tap_vector_encoder_if;
  logic        en;
  logic [15:0] T_in;
  logic [3:0]  Q;
  logic        q_valid;
  logic        q_locked;
  logic        err;
  logic [7:0]  err_count;

  modport master (output en, T_in, input Q, q_valid, q_locked, err, err_count);
  modport slave  (input en, T_in, output Q, q_valid, q_locked, err, err_count);
endinterface

// File: rtl/tap_vector_encoder.sv
// Encodes a one-hot delay-line tap vector back to the 4-bit tap code, with
// synchronization, illegal-pattern rejection and debounced lock tracking.
module tap_vector_encoder #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 4,
  parameter int ERR_LIMIT   = 3
) (
  input logic                 clk,
  input logic                 rst,
  tap_vector_encoder_if.slave bus_if
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [EW-1:0] ERR_MAX = EW'(ERR_LIMIT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

  logic [SYNC_STAGES-1:0][15:0] sync_q;
  logic [15:0]   s;
  logic [3:0]    code;
  logic          legal;

  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d, q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d, ncnt;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic          qv_q, qv_d, err_q, err_d;
  logic [7:0]    ecount_q, ecount_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else begin
      sync_q[0] <= bus_if.T_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign s = sync_q[SYNC_STAGES-1];

  // Same map as the decoder: no tap = code 0, tap k = code k+1, tap 15 unused.
  always_comb begin
    code  = '0;
    legal = 1'b0;
    if (s == '0) legal = 1'b1;
    else if ($onehot(s) && !s[15]) begin
      legal = 1'b1;
      for (int k = 0; k < 15; k++) if (s[k]) code = 4'(k + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      ecnt_q   <= '0;
      q_q      <= '0;
      qv_q     <= 1'b0;
      err_q    <= 1'b0;
      ecount_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      ecnt_q   <= ecnt_d;
      q_q      <= q_d;
      qv_q     <= qv_d;
      err_q    <= err_d;
      ecount_q <= ecount_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    ecnt_d   = ecnt_q;
    q_d      = q_q;
    qv_d     = 1'b0;
    err_d    = 1'b0;
    ecount_d = ecount_q;
    ncnt     = '0;
    // en low dominates: the observation on this edge is dropped.
    if (!bus_if.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      ecnt_d  = '0;
    end else if (state_q == IDLE) begin
      state_d  = ACQUIRE;
      ecount_d = '0;
    end else if (!legal) begin
      err_d  = 1'b1;
      cnt_d  = '0;
      if (ecount_q != 8'hFF) ecount_d = ecount_q + 8'd1;
      ecnt_d = (ecnt_q == ERR_MAX) ? ecnt_q : ecnt_q + 1'b1;
      if (state_q == LOCKED && ecnt_d == ERR_MAX) state_d = ACQUIRE;
    end else begin
      ecnt_d = '0;
      if (code == cand_q && cnt_q != '0)
        ncnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else
        ncnt = CW'(1);
      cand_d = code;
      cnt_d  = ncnt;
      // A steady code already presented while locked must not re-pulse q_valid.
      if (ncnt == CNT_MAX && (code != q_q || state_q == ACQUIRE)) begin
        q_d     = code;
        qv_d    = 1'b1;
        state_d = LOCKED;
      end
    end
  end

  always_comb begin
    bus_if.Q         = q_q;
    bus_if.q_valid   = qv_q;
    bus_if.q_locked  = (state_q == LOCKED);
    bus_if.err       = err_q;
    bus_if.err_count = ecount_q;
  end
endmodule

// File: tb/tb_tap_vector_encoder.sv
// Directed bench for tap_vector_encoder: hand sequences for lock/debounce/error
// corners, then a table sweep of every legal tap plus illegal patterns.
module tb_tap_vector_encoder;
  logic clk = 1'b0;
  logic rst;
  tap_vector_encoder_if bus ();

  tap_vector_encoder dut (.clk(clk), .rst(rst), .bus_if(bus));

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int both = 0;

  typedef struct {
    logic [15:0] t;
    logic [3:0]  q;
    logic        lk;
    logic [7:0]  ec;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges, sampling on each following negedge.
  task automatic run(input int n, output int nv, output int ne, output int unl, output int fv);
    nv = 0; ne = 0; unl = 0; fv = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.q_valid) begin
        nv++;
        if (fv < 0) fv = i;
      end
      if (bus.err) ne++;
      if (!bus.q_locked) unl++;
      if (bus.q_valid && bus.err) both++;
    end
  endtask

  initial begin
    int nv, ne, unl, fv;
    int snv, sne, sunl;

    tbl[0] = '{16'h0000, 4'd0, 1'b1, 8'd0};
    for (int k = 0; k < 15; k++) tbl[k+1] = '{16'h0001 << k, 4'(k + 1), 1'b1, 8'd0};
    tbl[16] = '{16'h8000, 4'd15, 1'b0, 8'd6};
    tbl[17] = '{16'h0003, 4'd15, 1'b0, 8'd14};
    tbl[18] = '{16'h0001, 4'd1,  1'b1, 8'd16};

    rst = 1'b1; bus.en = 1'b0; bus.T_in = '0;
    @(negedge clk); @(negedge clk);
    chk("reset Q", bus.Q, 0);
    chk("reset q_locked", bus.q_locked, 0);
    chk("reset q_valid", bus.q_valid, 0);
    chk("reset err", bus.err, 0);
    chk("reset err_count", bus.err_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Acquire: Q lands 5 edges after the vector is applied.
    bus.en = 1'b1; bus.T_in = 16'h0010;
    run(8, nv, ne, unl, fv);
    chk("acq q_valid count", nv, 1);
    chk("acq q_valid edge", fv, 5);
    chk("acq unlocked cycles", unl, 5);
    chk("acq Q", bus.Q, 5);
    chk("acq q_locked", bus.q_locked, 1);
    run(6, nv, ne, unl, fv);
    chk("held no repeat q_valid", nv, 0);

    // Two illegal observations while locked.
    bus.T_in = 16'h0003;
    run(2, nv, ne, unl, fv);
    sne = ne; snv = nv; sunl = unl;
    bus.T_in = 16'h0010;
    run(8, nv, ne, unl, fv);
    chk("ill2 err pulses", sne + ne, 2);
    chk("ill2 err_count", bus.err_count, 2);
    chk("ill2 stays locked", sunl + unl, 0);
    chk("ill2 no q_valid", snv + nv, 0);
    chk("ill2 Q", bus.Q, 5);

    // Three illegal observations drop lock, then relock to the same code.
    bus.T_in = 16'h8000;
    run(3, nv, ne, unl, fv);
    sne = ne;
    bus.T_in = 16'h0010;
    run(5, nv, ne, unl, fv);
    chk("ill3 err pulses", sne + ne, 3);
    chk("ill3 unlocked", bus.q_locked, 0);
    chk("ill3 Q held", bus.Q, 5);
    run(4, nv, ne, unl, fv);
    chk("relock q_valid", nv, 1);
    chk("relock Q", bus.Q, 5);
    chk("relock q_locked", bus.q_locked, 1);
    chk("relock err_count", bus.err_count, 5);

    // Toggling faster than STABLE_CNT never updates Q.
    snv = 0; sunl = 0;
    for (int c = 0; c < 10; c++) begin
      bus.T_in = (c % 2 == 0) ? 16'h0010 : 16'h0020;
      run(2, nv, ne, unl, fv);
      snv += nv; sunl += unl;
    end
    chk("toggle no q_valid", snv, 0);
    chk("toggle stays locked", sunl, 0);
    chk("toggle Q", bus.Q, 5);
    run(8, nv, ne, unl, fv);
    chk("settle q_valid", nv, 1);
    chk("settle Q", bus.Q, 6);
    chk("settle q_locked", bus.q_locked, 1);

    // en drops mid-debounce, then reacquires.
    bus.T_in = 16'h0100;
    run(3, nv, ne, unl, fv);
    snv = nv;
    bus.en = 1'b0;
    run(3, nv, ne, unl, fv);
    chk("en low no q_valid", snv + nv, 0);
    chk("en low Q held", bus.Q, 6);
    chk("en low q_locked", bus.q_locked, 0);
    chk("en low no err", ne, 0);
    bus.en = 1'b1;
    run(1, nv, ne, unl, fv);
    chk("en rise err_count clear", bus.err_count, 0);
    run(8, nv, ne, unl, fv);
    chk("reacq q_valid", nv, 1);
    chk("reacq Q", bus.Q, 9);
    chk("reacq q_locked", bus.q_locked, 1);

    // Asynchronous reset mid-debounce.
    bus.T_in = 16'h0004;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst Q", bus.Q, 0);
    chk("async rst q_locked", bus.q_locked, 0);
    chk("async rst q_valid", bus.q_valid, 0);
    chk("async rst err", bus.err, 0);
    chk("async rst err_count", bus.err_count, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      bus.T_in = tbl[i].t;
      run(8, nv, ne, unl, fv);
      chk($sformatf("tbl[%0d] Q", i), bus.Q, tbl[i].q);
      chk($sformatf("tbl[%0d] q_locked", i), bus.q_locked, tbl[i].lk);
      chk($sformatf("tbl[%0d] err_count", i), bus.err_count, tbl[i].ec);
    end

    chk("q_valid/err overlap cycles", both, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/tap_vector_encoder.md
Name: tap_vector_encoder

Overview:
- Inverse of the FMDLL 4-to-16 tap decoder: turns a 16-bit one-hot tap vector T_in back into the 4-bit tap code Q, using the same code map as the decoder.
- T_in is a delay-line tap snapshot or a loop-back of the decoder output from another timing domain.
- The block synchronizes T_in, rejects illegal patterns and debounces code changes. It then presents a stable, locked code to the DLL control loop.

Parameters:
- SYNC_STAGES, 2, number of flops in the T_in synchronizer (>=2).
- STABLE_CNT, 4, consecutive identical legal observations required before Q updates (>=1).
- ERR_LIMIT, 3, consecutive illegal observations that drop lock (>=1).

Ports:
- clk  input  1  sole clock; all flops rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  tracking enable; low = hold/idle.
- T_in  input  16  tap vector; asynchronous to clk.
- Q  output  4  encoded tap code (registered).
- q_valid  output  1  one-cycle pulse when Q is updated.
- q_locked  output  1  high in LOCKED state.
- err  output  1  one-cycle pulse per illegal observation.
- err_count  output  8  saturating count of illegal observations since reset / last en rise.

Behaviour:
- Reset (rst=1, async): all synchronizer flops 0, Q=0, q_valid=0, q_locked=0, err=0, err_count=0, cand=0, cnt=0, ecnt=0, state=IDLE.
- Synchronizer: T_in passes through SYNC_STAGES flops; s = last stage.
- Code map, combinational on s; matches the decoder exactly:
  - s==0 -> code 0, legal.
  - Exactly one bit k set, k in 0..14 -> code k+1, legal.
  - Bit 15 set, or more than one bit set -> illegal.
- Internal registers:
  - cand[3:0] = candidate code.
  - cnt = consecutive match count, saturates at STABLE_CNT.
  - ecnt = consecutive illegal count, saturates at ERR_LIMIT.
- States:
  - IDLE: en=0. Q held, q_locked=0, cnt=0, ecnt=0, no pulses. On en=1 -> ACQUIRE and err_count cleared that same edge.
  - ACQUIRE: en=1, not yet locked.
  - LOCKED: q_locked=1.
  - From any state, en=0 -> IDLE on the next edge. That observation is ignored.
- Observation rules each edge in ACQUIRE/LOCKED:
  - Illegal:
    - err=1 next cycle; err_count+1 (saturates at 255).
    - cnt<=0, cand unchanged; ecnt+1.
    - In LOCKED, if new ecnt==ERR_LIMIT -> ACQUIRE; Q held.
  - Legal:
    - ecnt<=0.
    - If code==cand and cnt!=0: ncnt=min(cnt+1,STABLE_CNT). Otherwise cand<=code and ncnt=1.
    - cnt<=ncnt.
    - If ncnt==STABLE_CNT and (code!=Q or state==ACQUIRE): Q<=code, q_valid=1 next cycle, state<=LOCKED.
    - No repeated q_valid while the code stays constant and the block is locked.
- Latency: T_in stable before edge e0 -> Q updates at edge e0+SYNC_STAGES+STABLE_CNT-1. With defaults that is 5 edges.
- STABLE_CNT=1: Q updates on the first legal observation.
- Simultaneous events: an en fall wins over any update. Reset mid-operation aborts immediately to reset values.
- A legal code that differs from Q while LOCKED is debounced the same way. q_locked stays high throughout.
- q_valid and err are mutually exclusive in any cycle.

Test Plan:
- Reset, then en=1, T_in=16'h0010 held -> Q=4'd5, q_valid pulse and q_locked=1 exactly 5 edges after T_in is applied; no further pulses while held.
- Locked at Q=5; T_in toggles 16'h0010/16'h0020 every 2 cycles for 20 cycles, then holds 16'h0020 -> no Q change during toggling; Q=4'd6 with one q_valid after settling.
- Locked; T_in=16'h0003 for 2 cycles, then 16'h0010 -> two err pulses, err_count=2, q_locked stays 1, Q stays 5.
- Locked; T_in=16'h8000 for 3 cycles -> err_count=3, q_locked drops after the 3rd observation, Q holds 5; restoring 16'h0010 relocks with a q_valid pulse and Q=5.
- en low mid-debounce of a new code 16'h0100 -> Q unchanged, state IDLE, q_locked=0; en high again -> err_count=0 and reacquire to Q=4'd9.
- Assert rst during a debounce -> Q=0 and all flags 0 immediately (asynchronous); sweep legal T_in values 0, 1<<0 … 1<<14 -> Q values 0..15 respectively.
